tank_level_model: RTL

//  Behavioural-synthesisable plant model of the water tank: the sensor end of the pump/sensor interface.

---
 rtl/tank_level_model.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tank_level_model.sv
// rtl/tank_level_model.sv - water tank plant model: integrates level from pump/drain, drives delayed sensors
module tank_level_model #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int LOW_TH     = 50,
  parameter int HIGH_TH    = 150,
  parameter int FILL_RATE  = 5,
  parameter int DRAIN_RATE = 2,
  parameter int TICK_DIV   = 4,
  parameter int SENSOR_DLY = 2,
  parameter int INIT_LEVEL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pump,
  input  logic               drain_en,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_level,
  input  logic               clr_flags,
  output logic               a,
  output logic               b,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         zone,
  output logic               overflow,
  output logic               dry
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W = LEVEL_W + 2;

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0]       MAX_L    = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0]       LOW_L    = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0]       HIGH_L   = LEVEL_W'(HIGH_TH);
  localparam logic [LEVEL_W-1:0]       INIT_L   = LEVEL_W'(INIT_LEVEL);
  localparam logic signed [SUM_W-1:0]  FILL_S   = SUM_W'(FILL_RATE);
  localparam logic signed [SUM_W-1:0]  DRAIN_S  = SUM_W'(DRAIN_RATE);
  localparam logic signed [SUM_W-1:0]  ZERO_S   = '0;
  localparam logic signed [SUM_W-1:0]  MAX_S    = SUM_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    Z_DRY  = 3'd0,
    Z_LOW  = 3'd1,
    Z_MID  = 3'd2,
    Z_HIGH = 3'd3,
    Z_FULL = 3'd4
  } zone_t;

  logic [CNT_W-1:0]       cnt;
  logic                   tick;
  logic signed [SUM_W-1:0] nxt;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [LEVEL_W-1:0]     load_clamped;
  logic [SENSOR_DLY-1:0]  a_pipe;
  logic [SENSOR_DLY-1:0]  b_pipe;
  zone_t                  zone_q;

  assign tick = (cnt == CNT_LAST);

  // Net delta is applied first so that simultaneous fill and drain only saturate on the result.
  always_comb begin
    nxt = $signed({2'b00, level}) + (pump ? FILL_S : ZERO_S) - (drain_en ? DRAIN_S : ZERO_S);
    sat_hi = tick && !load && (nxt > MAX_S);
    sat_lo = tick && !load && nxt[SUM_W-1];
    load_clamped = (load_level > MAX_L) ? MAX_L : load_level;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= INIT_L;
    end else if (load) begin
      level <= load_clamped;
    end else if (tick) begin
      if (sat_hi) begin
        level <= MAX_L;
      end else if (sat_lo) begin
        level <= '0;
      end else begin
        level <= nxt[LEVEL_W-1:0];
      end
    end
  end

  // A saturation in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      dry      <= 1'b0;
    end else begin
      if (sat_hi) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (sat_lo) begin
        dry <= 1'b1;
      end else if (clr_flags) begin
        dry <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe[0] <= (level >= LOW_L);
      b_pipe[0] <= (level >= HIGH_L);
      for (int i = 1; i < SENSOR_DLY; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  assign a = a_pipe[SENSOR_DLY-1];
  assign b = b_pipe[SENSOR_DLY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zone_q <= Z_DRY;
    end else begin
      if (level == '0) begin
        zone_q <= Z_DRY;
      end else if (level == MAX_L) begin
        zone_q <= Z_FULL;
      end else if (level >= HIGH_L) begin
        zone_q <= Z_HIGH;
      end else if (level < LOW_L) begin
        zone_q <= Z_LOW;
      end else begin
        zone_q <= Z_MID;
      end
    end
  end

  assign zone = zone_q;

endmodule
